// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op codes, FSM state codes, default width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // MULT and DIV work on magnitudes and restore signs at the end
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between EX control and the multiply/divide unit.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output Start, Op, OpA, OpB, input Busy, Done, HI, LO);
    modport slave  (input Start, Op, OpA, OpB, output Busy, Done, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for Start; MTHI/MTLO complete here in one edge
//  ST_CALC | one radix-2 multiply or divide step per cycle, WIDTH steps
//  ST_FIX  | restore result signs, write HI/LO, pulse Done
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    mult_div_unit_if.slave   bus
);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opd;       // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] r_acc;       // product, or quotient shift register in the low half
    logic [WIDTH:0]     r_rem;       // partial remainder
    logic               r_is_div;
    logic               r_neg_main;  // negate product / quotient
    logic               r_neg_rem;   // negate remainder
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rmd;

    // Operand magnitudes, one iteration step, and the final sign fix-up
    always_comb begin
        w_a_neg   = is_signed_op(bus.Op) && bus.OpA[WIDTH-1];
        w_b_neg   = is_signed_op(bus.Op) && bus.OpB[WIDTH-1];
        w_abs_a   = w_a_neg ? -bus.OpA : bus.OpA;
        w_abs_b   = w_b_neg ? -bus.OpB : bus.OpB;
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
        w_shift   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
        w_diff    = {1'b0, w_shift} - {2'b00, r_opd};
        w_prod    = r_neg_main ? -r_acc : r_acc;
        w_quo     = r_neg_main ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rmd     = r_neg_rem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end

    // Sequencer, datapath registers and HI/LO
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_opd      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        case (bus.Op)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                r_is_div   <= bus.Op[1];
                                r_opd      <= bus.Op[1] ? w_abs_b : w_abs_a;
                                r_acc      <= {{WIDTH{1'b0}}, (bus.Op[1] ? w_abs_a : w_abs_b)};
                                r_rem      <= '0;
                                r_neg_main <= w_a_neg ^ w_b_neg;
                                r_neg_rem  <= w_a_neg;
                                r_cnt      <= WIDTH'(WIDTH - 1);
                                r_state    <= ST_CALC;
                            end
                            MDU_MTHI: r_hi <= bus.OpA;
                            MDU_MTLO: r_lo <= bus.OpA;
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    if (r_is_div) begin
                        if (!w_diff[WIDTH+1]) begin
                            r_rem            <= w_diff[WIDTH:0];
                            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem            <= w_shift;
                            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rmd;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Busy = (r_state != ST_IDLE);
    assign bus.Done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected {HI,LO} queued at issue, compared at Done.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [63:0] sb_q[$];

    // Reference model: returns {HI, LO}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            MDU_MULT: res = sa * sb;
            MDU_MULTU: res = {32'b0, a} * {32'b0, b};
            MDU_DIV: begin
                if (b == 32'd0) res = {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Drive one Start for one cycle; queue the expected result for multi-cycle ops
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(negedge CLK);
        bus.Start = 1'b1;
        bus.Op = op;
        bus.OpA = a;
        bus.OpB = b;
        if (op <= MDU_DIVU) sb_q.push_back(exp);
        @(negedge CLK);
        bus.Start = 1'b0;
        bus.OpA = $urandom;
        bus.OpB = $urandom;
    endtask

    task automatic wait_done(output int busy_cycles, output bit timeout);
        int n;
        n = 0;
        busy_cycles = 0;
        while (!bus.Done && n < 200) begin
            if (bus.Busy) busy_cycles++;
            @(negedge CLK);
            n++;
        end
        timeout = !bus.Done;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.Start = 1'b0;
        bus.Op = 3'b111;
        bus.OpA = '0;
        bus.OpB = '0;
        #12;
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.Busy); end
        total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.Done); end
        total++; if ({bus.HI, bus.LO} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {bus.HI, bus.LO}); end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_multu_latency();
        int bc; bit to; logic [63:0] exp;
        issue(MDU_MULTU, 32'd7, 32'd6, {32'd0, 32'd42});
        wait_done(bc, to);
        exp = sb_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL multu_timeout no Done"); end
        total++; if (bc != 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d want=33", bc); end
        total++; if ({bus.HI, bus.LO} !== exp) begin bad++; $display("FAIL multu_result got=%h want=%h", {bus.HI, bus.LO}, exp); end
        @(negedge CLK);
        total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", bus.Done); end
    endtask

    task automatic test_spec_ops();
        logic [2:0]  ops[6] = '{MDU_MULT, MDU_MULTU, MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIVU};
        logic [31:0] as[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd5};
        logic [31:0] bs[6]  = '{32'd5, 32'hFFFFFFFF, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
        logic [63:0] ex[6]  = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFE_00000001, 64'h00000002_0000000E,
                                64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000, 64'h00000005_FFFFFFFF};
        int bc; bit to; logic [63:0] exp;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], ex[i]);
            wait_done(bc, to);
            exp = sb_q.pop_front();
            total++;
            if (to || {bus.HI, bus.LO} !== exp) begin
                bad++;
                $display("FAIL spec_op%0d op=%0d got=%h want=%h timeout=%0b", i, ops[i], {bus.HI, bus.LO}, exp, to);
            end
        end
    endtask

    task automatic test_div_zero_with_ignored_mthi();
        int bc; bit to; logic [63:0] exp; logic [31:0] hi_before;
        issue(MDU_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
        hi_before = bus.HI;
        repeat (8) @(negedge CLK);
        bus.Start = 1'b1; bus.Op = MDU_MTHI; bus.OpA = 32'd9;
        @(negedge CLK);
        bus.Start = 1'b0;
        total++; if (bus.HI !== hi_before || bus.Busy !== 1'b1) begin bad++; $display("FAIL busy_mthi_ignored hi=%h want=%h busy=%b", bus.HI, hi_before, bus.Busy); end
        wait_done(bc, to);
        exp = sb_q.pop_front();
        total++; if (to || {bus.HI, bus.LO} !== exp) begin bad++; $display("FAIL divu_zero got=%h want=%h timeout=%0b", {bus.HI, bus.LO}, exp, to); end
        @(negedge CLK);
        total++; if (bus.HI !== 32'd5 || bus.Busy !== 1'b0) begin bad++; $display("FAIL divu_zero_after hi=%h busy=%b want hi=5 busy=0", bus.HI, bus.Busy); end
    endtask

    task automatic test_mt_back_to_back();
        bit flag;
        flag = 1'b0;
        @(negedge CLK);
        bus.Start = 1'b1; bus.Op = MDU_MTHI; bus.OpA = 32'h1234;
        @(negedge CLK);
        flag |= bus.Busy | bus.Done;
        bus.Op = MDU_MTLO; bus.OpA = 32'h5678;
        @(negedge CLK);
        flag |= bus.Busy | bus.Done;
        bus.Start = 1'b1; bus.Op = 3'b111; bus.OpA = 32'hDEAD;
        @(negedge CLK);
        flag |= bus.Busy | bus.Done;
        bus.Start = 1'b0;
        total++; if ({bus.HI, bus.LO} !== 64'h00001234_00005678) begin bad++; $display("FAIL mt_hilo got=%h want=0000123400005678", {bus.HI, bus.LO}); end
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL mt_busy_done got=%b want=0", flag); end
    endtask

    task automatic test_reset_abort();
        int bc; bit to; logic [63:0] exp;
        issue(MDU_MULT, 32'd3, 32'd4, 64'd12);
        repeat (9) @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        total++; if (bus.Busy !== 1'b0 || {bus.HI, bus.LO} !== 64'd0) begin bad++; $display("FAIL async_abort busy=%b hilo=%h want 0/0", bus.Busy, {bus.HI, bus.LO}); end
        sb_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        issue(MDU_MULT, 32'hFFFFFFFE, 32'hFFFFFFF8, 64'd16);
        wait_done(bc, to);
        exp = sb_q.pop_front();
        total++; if (to || bc != 33 || {bus.HI, bus.LO} !== exp) begin bad++; $display("FAIL post_reset_mult got=%h want=%h busy=%0d", {bus.HI, bus.LO}, exp, bc); end
    endtask

    task automatic test_back_to_back();
        int bc; bit to; logic [63:0] exp;
        issue(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        wait_done(bc, to);
        exp = sb_q.pop_front();
        total++; if (to || {bus.HI, bus.LO} !== exp) begin bad++; $display("FAIL b2b_first got=%h want=%h", {bus.HI, bus.LO}, exp); end
        bus.Start = 1'b1; bus.Op = MDU_MULTU; bus.OpA = 32'h10000; bus.OpB = 32'h30000;
        sb_q.push_back(64'h00000003_00000000);
        @(negedge CLK);
        bus.Start = 1'b0;
        wait_done(bc, to);
        exp = sb_q.pop_front();
        total++; if (to || bc != 33 || {bus.HI, bus.LO} !== exp) begin bad++; $display("FAIL b2b_second got=%h want=%h busy=%0d", {bus.HI, bus.LO}, exp, bc); end
    endtask

    task automatic test_random();
        int bc; bit to; logic [63:0] exp; logic [2:0] op; logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 3));
            a = (i % 2 == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 400))) - 200);
            b = (i % 3 == 0) ? 32'($signed(32'($urandom_range(0, 40))) - 20) : $urandom;
            issue(op, a, b, model(op, a, b));
            wait_done(bc, to);
            exp = sb_q.pop_front();
            total++;
            if (to || {bus.HI, bus.LO} !== exp) begin
                bad++;
                $display("FAIL random%0d op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, {bus.HI, bus.LO}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_spec_ops();
        test_div_zero_with_ignored_mthi();
        test_mt_back_to_back();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
